reset_sequencer: RTL and testbench

//  Conditions the raw reset pushbutton into a clean, debounced request.

---
 rtl/reset_sequencer_pkg.sv | 17 +
 rtl/reset_sequencer_btn_debounce.sv | 54 +++++
 rtl/reset_sequencer.sv | 144 ++++++++++++++
 tb/tb_reset_sequencer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/reset_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// reset_seq_pkg
//   Shared types and constants for the reset sequencer slice.
//   rseq_state_t : sequencer FSM state (HOLD, RELEASE, RUN)
//   BTN_CNT_W    : width of the saturating button-reset counter
// -----------------------------------------------------------------------------
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD,
        RELEASE,
        RUN
    } rseq_state_t;

    localparam int BTN_CNT_W = 8;

endpackage

// File: rtl/reset_sequencer_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   Brings the raw reset pushbutton into the clk domain and accepts a new level
//   only after it has been stable for DEBOUNCE_CYCLES synchronized cycles.
//   Ports:
//     clk       in   system clock
//     rst_n     in   asynchronous active-low reset
//     btn_raw   in   raw pushbutton, asynchronous to clk
//     btn_db    out  debounced button level (registered)
//     btn_rise  out  one-cycle pulse, asserted together with a btn_db 0->1 update
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_db,
    output logic btn_rise
);

    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             btn_s;
    logic [CNT_W-1:0] stab_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1  <= 1'b0;
            btn_s    <= 1'b0;
            btn_db   <= 1'b0;
            btn_rise <= 1'b0;
            stab_cnt <= '0;
        end else begin
            sync_q1  <= btn_raw;
            btn_s    <= sync_q1;
            btn_rise <= 1'b0;
            // Any return to the accepted level restarts the stability window,
            // so short pulses never reach the terminal count.
            if (btn_s == btn_db) begin
                stab_cnt <= '0;
            end else if (stab_cnt == STAB_LAST) begin
                btn_db   <= btn_s;
                btn_rise <= btn_s;
                stab_cnt <= '0;
            end else begin
                stab_cnt <= stab_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//   Debounces the board reset button and releases NUM_STAGES downstream reset
//   domains in order (stage 0 first), STAGE_GAP cycles apart. A debounced
//   button press re-asserts every stage at once and restarts the sequence.
//   Ports:
//     clk            in   system clock
//     rst_n          in   asynchronous active-low power-on reset
//     rst_btn        in   raw pushbutton, active-high, asynchronous to clk
//     stage_rst      out  per-domain reset, active-high, registered
//     all_released   out  1 while in RUN (every stage released)
//     busy           out  1 whenever not in RUN
//     btn_reset_cnt  out  saturating count of button-initiated resets
// -----------------------------------------------------------------------------
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES      = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STAGE_GAP       = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rst_btn,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  all_released,
    output logic                  busy,
    output logic [BTN_CNT_W-1:0]  btn_reset_cnt
);

    localparam int CNT_MAX = (DEBOUNCE_CYCLES > STAGE_GAP) ? DEBOUNCE_CYCLES : STAGE_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(NUM_STAGES + 1);

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

    rseq_state_t      state;
    logic [CNT_W-1:0] gap_cnt;
    logic [IDX_W-1:0] idx;
    logic             btn_db;
    logic             btn_rise;

    function automatic logic [BTN_CNT_W-1:0] sat_inc(input logic [BTN_CNT_W-1:0] v);
        return (v == '1) ? v : v + BTN_CNT_W'(1);
    endfunction

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_btn_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (rst_btn),
        .btn_db   (btn_db),
        .btn_rise (btn_rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= HOLD;
            stage_rst     <= '1;
            all_released  <= 1'b0;
            busy          <= 1'b1;
            btn_reset_cnt <= '0;
            gap_cnt       <= '0;
            idx           <= '0;
        end else begin
            case (state)
                HOLD: begin
                    stage_rst <= '1;
                    // A held button parks the sequencer here; the gap only
                    // starts counting once the debounced button is released.
                    if (btn_db) begin
                        gap_cnt <= '0;
                    end else if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        if (NUM_STAGES == 1) begin
                            stage_rst    <= '0;
                            idx          <= '0;
                            state        <= RUN;
                            all_released <= 1'b1;
                            busy         <= 1'b0;
                        end else begin
                            stage_rst <= ~NUM_STAGES'(1);
                            idx       <= IDX_W'(1);
                            state     <= RELEASE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + CNT_W'(1);
                    end
                end

                RELEASE: begin
                    if (btn_rise) begin
                        state         <= HOLD;
                        stage_rst     <= '1;
                        gap_cnt       <= '0;
                        idx           <= '0;
                        all_released  <= 1'b0;
                        busy          <= 1'b1;
                        btn_reset_cnt <= sat_inc(btn_reset_cnt);
                    end else if (gap_cnt == GAP_LAST) begin
                        gap_cnt   <= '0;
                        // Only ever clears one more bit; released stages stay released.
                        stage_rst <= stage_rst & ~(NUM_STAGES'(1) << idx);
                        if (idx == IDX_LAST) begin
                            idx          <= '0;
                            state        <= RUN;
                            all_released <= 1'b1;
                            busy         <= 1'b0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        gap_cnt <= gap_cnt + CNT_W'(1);
                    end
                end

                RUN: begin
                    if (btn_rise) begin
                        state         <= HOLD;
                        stage_rst     <= '1;
                        gap_cnt       <= '0;
                        idx           <= '0;
                        all_released  <= 1'b0;
                        busy          <= 1'b1;
                        btn_reset_cnt <= sat_inc(btn_reset_cnt);
                    end
                end

                default: begin
                    state        <= HOLD;
                    stage_rst    <= '1;
                    gap_cnt      <= '0;
                    idx          <= '0;
                    all_released <= 1'b0;
                    busy         <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//   Directed bench for reset_sequencer with NUM_STAGES=4, DEBOUNCE_CYCLES=8,
//   STAGE_GAP=4. Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

    logic       clk;
    logic       rst_n;
    logic       rst_btn;
    logic [3:0] stage_rst;
    logic       all_released;
    logic       busy;
    logic [7:0] btn_reset_cnt;

    int checks;
    int failures;
    int found;

    reset_sequencer #(
        .NUM_STAGES      (4),
        .DEBOUNCE_CYCLES (8),
        .STAGE_GAP       (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rst_btn       (rst_btn),
        .stage_rst     (stage_rst),
        .all_released  (all_released),
        .busy          (busy),
        .btn_reset_cnt (btn_reset_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Stage k is still in reset until edge base + 4*(k+1).
    function automatic logic [3:0] exp_stages(input int edge_n, input int base);
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = (edge_n < base + 4 * (k + 1));
        return v;
    endfunction

    // Drop the button (debounced fall lands 10 edges later) and follow the
    // full release sequence into RUN.
    task automatic release_and_check(input string tag);
        rst_btn = 1'b0;
        for (int r = 1; r <= 26; r++) begin
            @(negedge clk);
            check({tag, "_stage"}, 32'(stage_rst), 32'(exp_stages(r, 10)));
            if (r == 25) check({tag, "_allrel_pre"}, 32'(all_released), 32'd0);
            if (r == 26) begin
                check({tag, "_allrel"}, 32'(all_released), 32'd1);
                check({tag, "_busy"}, 32'(busy), 32'd0);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        rst_btn  = 1'b0;

        // Power-up
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stage", 32'(stage_rst), 32'hF);
        check("rst_allrel", 32'(all_released), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_cnt", 32'(btn_reset_cnt), 32'd0);
        rst_n = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            @(negedge clk);
            check("pwr_stage", 32'(stage_rst), 32'(exp_stages(e, 0)));
            if (e == 15) check("pwr_allrel_pre", 32'(all_released), 32'd0);
            if (e == 16) begin
                check("pwr_allrel", 32'(all_released), 32'd1);
                check("pwr_busy", 32'(busy), 32'd0);
                check("pwr_cnt", 32'(btn_reset_cnt), 32'd0);
            end
        end

        // Glitch: 5-cycle pulse must be ignored
        rst_btn = 1'b1;
        repeat (5) @(negedge clk);
        rst_btn = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch_stage", 32'(stage_rst), 32'h0);
        check("glitch_cnt", 32'(btn_reset_cnt), 32'd0);
        check("glitch_allrel", 32'(all_released), 32'd1);

        // Button press from RUN, held 20 cycles
        rst_btn = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            if (e == 10) check("press_stage_pre", 32'(stage_rst), 32'h0);
            if (e == 11) begin
                check("press_stage", 32'(stage_rst), 32'hF);
                check("press_cnt", 32'(btn_reset_cnt), 32'd1);
                check("press_busy", 32'(busy), 32'd1);
                check("press_allrel", 32'(all_released), 32'd0);
            end
            if (e == 20) check("press_hold", 32'(stage_rst), 32'hF);
        end
        release_and_check("press_rel");

        // Async reset while in RELEASE
        rst_btn = 1'b1;
        repeat (12) @(negedge clk);
        check("press2_cnt", 32'(btn_reset_cnt), 32'd2);
        rst_btn = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge clk);
            if (stage_rst == 4'b1100) found = 1;
        end
        check("wait_1100", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_stage", 32'(stage_rst), 32'hF);
        check("async_cnt", 32'(btn_reset_cnt), 32'd0);
        check("async_busy", 32'(busy), 32'd1);
        check("async_allrel", 32'(all_released), 32'd0);

        // Mid-sequence press: button held through reset release, its debounced
        // rise lands while stage_rst=1100
        @(negedge clk);
        rst_btn = 1'b1;
        @(negedge clk);
        check("mid_rst_stage", 32'(stage_rst), 32'hF);
        rst_n = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            @(negedge clk);
            if (e <= 10) check("mid_stage", 32'(stage_rst), 32'(exp_stages(e, 0)));
            else         check("mid_hold", 32'(stage_rst), 32'hF);
            if (e == 10) check("mid_cnt_pre", 32'(btn_reset_cnt), 32'd0);
            if (e == 11) check("mid_cnt", 32'(btn_reset_cnt), 32'd1);
        end
        release_and_check("mid_rel");

        // Saturation: 299 more presses on top of the one above
        for (int i = 1; i <= 299; i++) begin
            rst_btn = 1'b1;
            repeat (12) @(negedge clk);
            rst_btn = 1'b0;
            repeat (16) @(negedge clk);
            if (i == 1)   check("sat_cnt_2", 32'(btn_reset_cnt), 32'd2);
            if (i == 253) check("sat_cnt_fe", 32'(btn_reset_cnt), 32'hFE);
            if (i == 254) check("sat_cnt_ff", 32'(btn_reset_cnt), 32'hFF);
        end
        check("sat_cnt_end", 32'(btn_reset_cnt), 32'hFF);
        repeat (12) @(negedge clk);
        check("sat_stage", 32'(stage_rst), 32'h0);
        check("sat_allrel", 32'(all_released), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
